// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate arbiter.
package parking_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } gate_state_e;

    typedef enum logic {
        ENTRY = 1'b0,
        EXIT  = 1'b1
    } requester_e;

    localparam int unsigned CAPACITY_DEF  = 8;
    localparam int unsigned DOOR_HOLD_DEF = 24;

endpackage : parking_pkg

// File: rtl/gate_hold_timer.sv
// Loadable down-counter that times the door hold-off window.
module gate_hold_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_2Hz,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load on grant, otherwise count down and rest at zero.
    always_ff @(posedge clk_2Hz or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule : gate_hold_timer

// File: rtl/parking_gate_arbiter.sv
// Shares one barrier door between entry and exit sensors and tracks occupancy.
// Build option: define GATE_ROUND_ROBIN_EN to alternate between entry and exit
// when both are eligible; otherwise exit has fixed priority.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY  = CAPACITY_DEF,
    parameter int unsigned DOOR_HOLD = DOOR_HOLD_DEF
) (
    input  logic                             clk_2Hz,
    input  logic                             reset,
    input  logic                             entry_req,
    input  logic                             exit_req,
    output logic                             open_signal,
    output logic                             entry_ack,
    output logic                             exit_ack,
    output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned OCC_W   = $clog2(CAPACITY + 1);
    localparam int unsigned TIMER_W = $clog2(DOOR_HOLD);

    gate_state_e      state, state_n;
    requester_e       last_served, last_n;
    logic             entry_prev, exit_prev;
    logic             entry_pend, exit_pend;
    logic             entry_pend_n, exit_pend_n;
    logic             open_n, entry_ack_n, exit_ack_n;
    logic [OCC_W-1:0] occ_n;
    logic             timer_load, timer_expired;
    logic             grant_entry, grant_exit;
    logic             entry_rise, exit_rise;
    logic             entry_elig, exit_elig;

    assign entry_rise = entry_req & ~entry_prev;
    assign exit_rise  = exit_req  & ~exit_prev;
    assign full       = (occupancy == OCC_W'(CAPACITY));
    assign empty      = (occupancy == '0);
    assign entry_elig = entry_pend & ~full;
    assign exit_elig  = exit_pend;

    gate_hold_timer #(
        .WIDTH (TIMER_W)
    ) u_hold_timer (
        .clk_2Hz    (clk_2Hz),
        .reset      (reset),
        .load       (timer_load),
        .load_value (TIMER_W'(DOOR_HOLD - 1)),
        .expired    (timer_expired)
    );

    // Arbitration, occupancy arithmetic and sticky request bookkeeping.
    always_comb begin
        state_n     = state;
        last_n      = last_served;
        occ_n       = occupancy;
        open_n      = 1'b0;
        entry_ack_n = 1'b0;
        exit_ack_n  = 1'b0;
        timer_load  = 1'b0;
        grant_entry = 1'b0;
        grant_exit  = 1'b0;

        case (state)
            IDLE: begin
                if (entry_elig || exit_elig) begin
`ifdef GATE_ROUND_ROBIN_EN
                    grant_entry = entry_elig && (!exit_elig || (last_served == EXIT));
`else
                    grant_entry = entry_elig && !exit_elig;
`endif
                    grant_exit  = !grant_entry;
                    open_n      = 1'b1;
                    timer_load  = 1'b1;
                    state_n     = HOLD;
                    if (grant_entry) begin
                        entry_ack_n = 1'b1;
                        occ_n       = occupancy + OCC_W'(1);
                        last_n      = ENTRY;
                    end else begin
                        exit_ack_n  = 1'b1;
                        // Exit at an empty lot still opens the door but saturates.
                        if (!empty) begin
                            occ_n = occupancy - OCC_W'(1);
                        end
                        last_n      = EXIT;
                    end
                end
            end
            HOLD: begin
                if (timer_expired) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A fresh rise wins over a same-edge grant clear.
        entry_pend_n = entry_rise | (entry_pend & ~grant_entry);
        exit_pend_n  = exit_rise  | (exit_pend  & ~grant_exit);
    end

    // State, request history and registered outputs.
    always_ff @(posedge clk_2Hz or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= EXIT;
            entry_prev  <= 1'b0;
            exit_prev   <= 1'b0;
            entry_pend  <= 1'b0;
            exit_pend   <= 1'b0;
            open_signal <= 1'b0;
            entry_ack   <= 1'b0;
            exit_ack    <= 1'b0;
            occupancy   <= '0;
        end else begin
            state       <= state_n;
            last_served <= last_n;
            entry_prev  <= entry_req;
            exit_prev   <= exit_req;
            entry_pend  <= entry_pend_n;
            exit_pend   <= exit_pend_n;
            open_signal <= open_n;
            entry_ack   <= entry_ack_n;
            exit_ack    <= exit_ack_n;
            occupancy   <= occ_n;
        end
    end

endmodule : parking_gate_arbiter

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares the single barrier door between the entry and exit sensors of the parking lot. It tracks lot occupancy and issues one-cycle open pulses to the door block's `open_signal`. After each pulse it holds off further grants for a fixed window that covers the door's blink-and-close sequence. Entries are refused while the lot is full; refused entries stay pending until space frees.

## Interface
Parameters:
- `CAPACITY`, 8: number of parking spaces (1..255).
- `DOOR_HOLD`, 24: cycles from an open pulse until the next grant is allowed; must be ≥ 22.

Ports:
- `clk_2Hz` input 1: the single system clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `entry_req` input 1: entry sensor, level.
- `exit_req` input 1: exit sensor, level.
- `open_signal` output 1: one-cycle door-open pulse, driven to the door block.
- `entry_ack` output 1: one-cycle pulse when an entry is granted.
- `exit_ack` output 1: one-cycle pulse when an exit is granted.
- `occupancy` output $clog2(CAPACITY+1): number of cars currently inside.
- `full` output 1: high when `occupancy == CAPACITY` (combinational from the register).
- `empty` output 1: high when `occupancy == 0`.

## Operation
- Reset values: all outputs 0 except `empty` = 1. Internal state: state = IDLE, timer = 0, pending bits = 0, request history = 0, `last_served` = EXIT.
- Request capture:
  - Each request is rising-edge detected against its previous-cycle value.
  - A rise sets the sticky bit `entry_pend` or `exit_pend`.
  - A held sensor never re-triggers a request.
  - A set and a clear on the same edge: set wins.
- Eligibility:
  - Exit is eligible when `exit_pend` = 1.
  - Entry is eligible when `entry_pend` = 1 and not full.
- FSM states: IDLE, HOLD.
  - IDLE with no eligible request: stay in IDLE.
  - IDLE with at least one eligible request, on that edge:
    - choose a winner (see Configuration);
    - register `open_signal` = 1 and the winner's ack = 1;
    - clear the winner's pending bit;
    - add or subtract 1 from occupancy;
    - update `last_served`;
    - load timer = DOOR_HOLD−1;
    - go to HOLD.
  - HOLD: `open_signal` and the acks return to 0 on the next edge. The timer decrements each cycle; when the timer is 0, go to IDLE.
- Arithmetic: occupancy never wraps. Entry is blocked at CAPACITY. An exit granted at 0 still opens the door, but occupancy stays 0 (saturation).
- A pending entry blocked by full does not block exit service.
- Requests arriving during HOLD are latched and served after HOLD ends.
- Reset asserted mid-HOLD or mid-pulse: everything returns immediately to the reset values, and the pulse is truncated.

## Timing
- Request rises before edge E0: the pending bit is set at E0. At E1 `open_signal` and the ack go high; at E2 they go low. Request-to-pulse latency is 2 edges.
- Occupancy and `full`/`empty` update at E1, the same edge as the ack.
- Grant spacing: consecutive open pulses are exactly DOOR_HOLD+1 cycles apart when requests are back-to-back.
- At most one grant per HOLD window; `open_signal` is never high on two consecutive cycles.

## Configuration
- Macro `GATE_ROUND_ROBIN_EN`.
  - Defined: when both requests are eligible, serve the opposite of `last_served`.
  - Undefined: fixed priority, exit wins. `last_served` is still maintained but unused.
- A single eligible request is served identically in both builds.

## Structure
- Shared package `parking_pkg` holds:
  - the state enum (IDLE, HOLD);
  - the requester enum (ENTRY, EXIT) used for `last_served`;
  - the defaults `CAPACITY_DEF` = 8 and `DOOR_HOLD_DEF` = 24.
- Sub-module `gate_hold_timer` holds the loadable down-counter. It has inputs `load` and `load_value` and output `expired`. It is reset to 0.

## Test plan
- Reset with `CAPACITY` = 8, then a single 3-cycle entry pulse:
  - 2 edges later, `open_signal` and `entry_ack` pulse for 1 cycle;
  - `occupancy` = 1, `empty` = 0;
  - there is no second pulse while `entry_req` is held.
- Fill with 8 entries, then raise `entry_req`:
  - `full` = 1 and no grant occurs;
  - a later exit is granted with `occupancy` = 7;
  - the held entry is then granted after HOLD, with `occupancy` = 8.
- Rise `entry_req` and `exit_req` on the same edge with `occupancy` = 3:
  - with the macro, `last_served` = EXIT, so entry goes first (occ 4), then exit DOOR_HOLD+1 cycles later (occ 3);
  - without the macro, exit goes first.
- With `occupancy` = 0, raise `exit_req`: `open_signal` pulses, `exit_ack` = 1, `occupancy` stays 0.
- During HOLD, raise `entry_req` at cycle 5: no pulse until HOLD ends, then exactly one grant, spaced 25 cycles from the previous one.
- Drop `reset` on the cycle `open_signal` = 1: all outputs are 0 immediately and `empty` = 1; after release, the old pending request is not served.
